// File: rtl/siso_xfer_pkg.sv
// siso_xfer_pkg
//   Shared definitions for the SISO transfer controller.
//   - state_t : FSM state encoding (S_IDLE, S_SHIFT, S_DONE)
//   - clog2   : width helper for the transfer counter (never below 1 bit)
package siso_xfer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/siso_chain.sv
// siso_chain
//   DEPTH enabled D flip-flops in series. This is the delay line that
//   siso_xfer_ctrl drives. The flops are deliberately not reset.
// Ports:
//   clk : clock, rising edge
//   en  : shift enable
//   d   : serial data into stage 0
//   q   : serial data from stage DEPTH-1
module siso_chain #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic en,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stage;

  always_ff @(posedge clk) begin
    if (en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/siso_xfer_ctrl.sv
// siso_xfer_ctrl
//   Accepts a parallel word, shifts it LSB-first into an external SISO chain
//   of DEPTH flops, flushes it through with zero fill, reassembles the chain
//   output, and presents the word on an output handshake.
// Ports:
//   clk, rst           : clock (rising edge), synchronous active-low reset
//   in_valid/in_ready  : input handshake, in_data is the word to serialize
//   out_valid/out_ready: output handshake, out_data is the reassembled word
//   busy               : SHIFT or DONE
//   ser_d/ser_en/ser_q : chain serial input, shift enable, chain output
//   err                : reassembled word differs from the accepted word
// Build option:
//   SISO_XFER_CHECK_EN : when defined, keeps the accepted word and raises err
//                        with out_valid if the chain returned something else.
//                        When undefined, err is tied low.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a word; handshake latches in_data, count <= 0
// S_SHIFT | one chain shift per cycle; captures ser_q once count>=DEPTH
// S_DONE  | out_valid held with the captured word until out_ready
module siso_xfer_ctrl
  import siso_xfer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             ser_d,
  output logic             ser_en,
  input  logic             ser_q,
  output logic             err
);

  localparam int CW = clog2(WIDTH + DEPTH);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] cap_nxt;
  logic             last_shift;

  assign last_shift = (count == CW'(WIDTH + DEPTH - 1));

  // The chain output seen at count c is the bit pushed DEPTH edges earlier,
  // i.e. word bit c-DEPTH. Earlier counts only see stale chain contents.
  always_comb begin
    cap_nxt = cap;
    for (int i = 0; i < WIDTH; i++) begin
      if (count == CW'(i + DEPTH)) begin
        cap_nxt[i] = ser_q;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ser_en    = 1'b0;
    ser_d     = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        ser_en = 1'b1;
        ser_d  = shreg[0];
        busy   = 1'b1;
        if (last_shift) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy = 1'b1;
        if (out_valid && out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count     <= '0;
      shreg     <= '0;
      cap       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            shreg <= in_data;
            count <= '0;
            cap   <= '0;
          end
        end
        S_SHIFT: begin
          shreg <= shreg >> 1;
          cap   <= cap_nxt;
          if (last_shift) begin
            out_valid <= 1'b1;
            out_data  <= cap_nxt;
          end else begin
            // Held at the final value so it cannot wrap when WIDTH+DEPTH
            // is a power of two.
            count <= count + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SISO_XFER_CHECK_EN
  logic [WIDTH-1:0] ref_word;
  logic             err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ref_word <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == S_IDLE && in_valid) ref_word <= in_data;
      if (state == S_SHIFT && last_shift) err_q <= (cap_nxt != ref_word);
      else if (state == S_DONE && out_ready) err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
